// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencing for the IF stage.
// Drives the PC load enable / next-PC value and the I-cache request, handles
// cache refills (MISS_WAIT), branch redirects (immediate in FETCH, deferred to
// refill completion in MISS_WAIT) and a terminal HALTED state.
// Optional feature: define FETCH_MISALIGN_TRAP_EN to send misaligned redirect
// targets to TRAP_VECTOR with a misalign_trap pulse; otherwise the target is
// word-aligned by clearing bits [1:0].
module fetch_ctrl #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic        icache_ready,
  input  logic        icache_miss,
  input  logic        hazard_stall,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  input  logic        halt,
  output logic        pc_en,
  output logic [31:0] pc_next,
  output logic        icache_req,
  output logic        if_flush,
  output logic        misalign_trap
);

  typedef enum logic [1:0] {
    BOOT,
    FETCH,
    MISS_WAIT,
    HALTED
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic        pend_valid;
  logic        pend_valid_nx;
  logic [31:0] pend_target;
  logic [31:0] pend_target_nx;

  logic [31:0] pc_seq;
  logic        apply_redir;
  logic [31:0] apply_src;

  assign pc_seq = pc + 32'd4;

  // State and pending-redirect registers, cleared asynchronously by reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= BOOT;
      pend_valid  <= 1'b0;
      pend_target <= '0;
    end else begin
      state       <= state_nx;
      pend_valid  <= pend_valid_nx;
      pend_target <= pend_target_nx;
    end
  end

  // Next-state and pending-redirect bookkeeping
  always_comb begin
    state_nx       = state;
    pend_valid_nx  = pend_valid;
    pend_target_nx = pend_target;
    case (state)
      BOOT: state_nx = FETCH;
      FETCH: begin
        if (halt) begin
          state_nx = HALTED;
        end else if (!redirect && icache_miss) begin
          state_nx = MISS_WAIT;
        end
      end
      MISS_WAIT: begin
        if (halt) begin
          state_nx      = HALTED;
          pend_valid_nx = 1'b0;
        end else if (icache_ready) begin
          state_nx      = FETCH;
          pend_valid_nx = 1'b0;
        end else if (redirect) begin
          pend_valid_nx  = 1'b1;
          pend_target_nx = redirect_target;
        end
      end
      HALTED: state_nx = HALTED;
      default: state_nx = BOOT;
    endcase
  end

  // Outputs: decided from state and current inputs only (never from pc_en)
  always_comb begin
    pc_en         = 1'b0;
    pc_next       = pc;
    icache_req    = 1'b0;
    if_flush      = 1'b0;
    misalign_trap = 1'b0;
    apply_redir   = 1'b0;
    apply_src     = redirect_target;
    if (reset) begin
      pc_next = RESET_VECTOR;
    end else begin
      case (state)
        BOOT: begin
          pc_en   = 1'b1;
          pc_next = RESET_VECTOR;
        end
        FETCH: begin
          if (!halt) begin
            icache_req = 1'b1;
            if (redirect) begin
              apply_redir = 1'b1;
            end else if (!icache_miss && !hazard_stall && icache_ready) begin
              pc_en   = 1'b1;
              pc_next = pc_seq;
            end
          end
        end
        MISS_WAIT: begin
          if (!halt) begin
            icache_req = 1'b1;
            // A live redirect on the refill-completion cycle beats the latched one
            if (icache_ready) begin
              if (redirect) begin
                apply_redir = 1'b1;
              end else if (pend_valid) begin
                apply_redir = 1'b1;
                apply_src   = pend_target;
              end
            end
          end
        end
        default: begin
        end
      endcase

      if (apply_redir) begin
        pc_en    = 1'b1;
        if_flush = 1'b1;
`ifdef FETCH_MISALIGN_TRAP_EN
        if (apply_src[1:0] != 2'b00) begin
          pc_next       = TRAP_VECTOR;
          misalign_trap = 1'b1;
        end else begin
          pc_next = apply_src;
        end
`else
        pc_next = {apply_src[31:2], 2'b00};
`endif
      end
    end
  end

`ifndef FETCH_MISALIGN_TRAP_EN
  logic unused_cfg;
  assign unused_cfg = ^{apply_src[1:0], TRAP_VECTOR};
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed test of fetch_ctrl against a behavioural model.
// The model tracks "booted / refilling / halted" flags plus a count and the
// most recent value of redirects seen during a refill, and derives expected
// outputs from the fetch rules each cycle. Directed vectors add literal
// expectations that pin the model. Build with or without FETCH_MISALIGN_TRAP_EN.
module tb_fetch_ctrl;

  localparam logic [31:0] RV = 32'h0000_0000;
  localparam logic [31:0] TV = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pc = '0;
  logic        icache_ready = 1'b0;
  logic        icache_miss = 1'b0;
  logic        hazard_stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_target = '0;
  logic        halt = 1'b0;
  logic        pc_en;
  logic [31:0] pc_next;
  logic        icache_req;
  logic        if_flush;
  logic        misalign_trap;

  always #5 clk = ~clk;

  fetch_ctrl #(.RESET_VECTOR(RV), .TRAP_VECTOR(TV)) dut (
    .clk(clk), .reset(reset), .pc(pc), .icache_ready(icache_ready),
    .icache_miss(icache_miss), .hazard_stall(hazard_stall), .redirect(redirect),
    .redirect_target(redirect_target), .halt(halt), .pc_en(pc_en),
    .pc_next(pc_next), .icache_req(icache_req), .if_flush(if_flush),
    .misalign_trap(misalign_trap)
  );

  int checks = 0;
  int passes = 0;

  // Literal expectation requested by the stimulus for the current cycle
  bit          lit_on = 1'b0;
  string       lit_name = "";
  logic        lit_en = 1'b0;
  logic [31:0] lit_nxt = '0;
  logic        lit_req = 1'b0;
  logic        lit_fl = 1'b0;
  logic        lit_tr = 1'b0;

  // Model state (committed) and its value for the next cycle
  bit          m_booted, m_refill, m_halted;
  int          m_pend_cnt;
  logic [31:0] m_pend_last;
  bit          n_booted, n_refill, n_halted;
  int          n_pend_cnt;
  logic [31:0] n_pend_last;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h at t=%0t", nm, act, exp, $time);
  endtask

  function automatic void shape(input logic [31:0] t, output logic [31:0] o, output logic tr);
`ifdef FETCH_MISALIGN_TRAP_EN
    tr = (t % 4) != 0;
    o  = tr ? TV : t;
`else
    tr = 1'b0;
    o  = t - (t % 4);
`endif
  endfunction

  // Compare process: model prediction and literal expectations, every cycle
  always @(negedge clk) begin
    logic        e_en, e_req, e_fl, e_tr, take;
    logic [31:0] e_nxt, tgt;
    e_en = 1'b0; e_req = 1'b0; e_fl = 1'b0; e_tr = 1'b0; e_nxt = RV;
    take = 1'b0; tgt = redirect_target;
    n_booted = m_booted; n_refill = m_refill; n_halted = m_halted;
    n_pend_cnt = m_pend_cnt; n_pend_last = m_pend_last;
    if (reset) begin
      n_booted = 1'b0; n_refill = 1'b0; n_halted = 1'b0; n_pend_cnt = 0; n_pend_last = '0;
    end else if (!m_booted) begin
      e_en = 1'b1; n_booted = 1'b1;
    end else if (m_halted) begin
      e_en = 1'b0;
    end else if (halt) begin
      n_halted = 1'b1; n_refill = 1'b0; n_pend_cnt = 0;
    end else if (!m_refill) begin
      e_req = 1'b1;
      if (redirect) take = 1'b1;
      else if (icache_miss) n_refill = 1'b1;
      else if (icache_ready && !hazard_stall) begin
        e_en = 1'b1; e_nxt = pc + 32'd4;
      end
    end else begin
      e_req = 1'b1;
      if (icache_ready) begin
        n_refill = 1'b0; n_pend_cnt = 0;
        if (redirect) take = 1'b1;
        else if (m_pend_cnt > 0) begin take = 1'b1; tgt = m_pend_last; end
      end else if (redirect) begin
        n_pend_cnt = m_pend_cnt + 1; n_pend_last = redirect_target;
      end
    end
    if (take) begin
      e_en = 1'b1; e_fl = 1'b1; shape(tgt, e_nxt, e_tr);
    end
    chk("model_pc_en", {31'b0, pc_en}, {31'b0, e_en});
    chk("model_icache_req", {31'b0, icache_req}, {31'b0, e_req});
    chk("model_if_flush", {31'b0, if_flush}, {31'b0, e_fl});
    chk("model_misalign_trap", {31'b0, misalign_trap}, {31'b0, e_tr});
    if (reset || e_en) chk("model_pc_next", pc_next, e_nxt);
    if (lit_on) begin
      chk({lit_name, "_pc_en"}, {31'b0, pc_en}, {31'b0, lit_en});
      if (lit_en) chk({lit_name, "_pc_next"}, pc_next, lit_nxt);
      chk({lit_name, "_icache_req"}, {31'b0, icache_req}, {31'b0, lit_req});
      chk({lit_name, "_if_flush"}, {31'b0, if_flush}, {31'b0, lit_fl});
      chk({lit_name, "_trap"}, {31'b0, misalign_trap}, {31'b0, lit_tr});
    end
  end

  // Model state commit, reset asynchronously like the design
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_booted <= 1'b0; m_refill <= 1'b0; m_halted <= 1'b0;
      m_pend_cnt <= 0; m_pend_last <= '0;
    end else begin
      m_booted <= n_booted; m_refill <= n_refill; m_halted <= n_halted;
      m_pend_cnt <= n_pend_cnt; m_pend_last <= n_pend_last;
    end
  end

  bit          track = 1'b0;
  logic        s_en;
  logic [31:0] s_nxt;

  // One clock cycle; optional literal expectation; optional PC register emulation
  task automatic cyc(input bit lit, input string nm, input logic en, input logic [31:0] nxt,
                     input logic req, input logic fl, input logic tr);
    lit_on = lit; lit_name = nm; lit_en = en; lit_nxt = nxt;
    lit_req = req; lit_fl = fl; lit_tr = tr;
    @(negedge clk);
    s_en = pc_en; s_nxt = pc_next;
    @(posedge clk); #1;
    lit_on = 1'b0;
    if (track && s_en) pc = s_nxt;
  endtask

  task automatic enter_miss();
    icache_ready = 1'b0; icache_miss = 1'b1;
    cyc(1, "miss", 1'b0, '0, 1'b1, 1'b0, 1'b0);
    icache_miss = 1'b0;
  endtask

  task automatic redir_cyc(input logic [31:0] t);
    redirect = 1'b1; redirect_target = t;
    cyc(1, "mw_redir", 1'b0, '0, 1'b1, 1'b0, 1'b0);
    redirect = 1'b0;
  endtask

  initial begin
    logic [31:0] mis_nxt;
    logic        mis_tr;
`ifdef FETCH_MISALIGN_TRAP_EN
    mis_nxt = 32'h0000_0100; mis_tr = 1'b1;
`else
    mis_nxt = 32'h0000_0200; mis_tr = 1'b0;
`endif
    // Reset, then sequential fetch from RESET_VECTOR
    cyc(1, "rst", 1'b0, '0, 1'b0, 1'b0, 1'b0);
    cyc(1, "rst", 1'b0, '0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0; track = 1'b1; pc = '0; icache_ready = 1'b1;
    cyc(1, "boot", 1'b1, 32'h0, 1'b0, 1'b0, 1'b0);
    cyc(1, "seq4", 1'b1, 32'h4, 1'b1, 1'b0, 1'b0);
    cyc(1, "seq8", 1'b1, 32'h8, 1'b1, 1'b0, 1'b0);
    cyc(1, "seq12", 1'b1, 32'hC, 1'b1, 1'b0, 1'b0);

    // Refill: miss then ready after 5 cycles, six cycles with pc_en low
    track = 1'b0; pc = 32'h40;
    enter_miss();
    repeat (4) cyc(1, "mw_wait", 1'b0, '0, 1'b1, 1'b0, 1'b0);
    icache_ready = 1'b1;
    cyc(1, "mw_exit", 1'b0, '0, 1'b1, 1'b0, 1'b0);
    cyc(1, "post_refill", 1'b1, 32'h44, 1'b1, 1'b0, 1'b0);

    // Redirect latched during refill, applied on completion
    enter_miss();
    cyc(1, "mw_wait", 1'b0, '0, 1'b1, 1'b0, 1'b0);
    redir_cyc(32'h200);
    repeat (2) cyc(1, "mw_wait", 1'b0, '0, 1'b1, 1'b0, 1'b0);
    icache_ready = 1'b1;
    cyc(1, "pend_apply", 1'b1, 32'h200, 1'b1, 1'b1, 1'b0);
    cyc(1, "pend_cleared", 1'b1, 32'h44, 1'b1, 1'b0, 1'b0);

    // Later redirect overwrites the latched target
    enter_miss();
    redir_cyc(32'h300);
    redir_cyc(32'h340);
    icache_ready = 1'b1;
    cyc(1, "pend_overwrite", 1'b1, 32'h340, 1'b1, 1'b1, 1'b0);

    // Live redirect on the exit cycle beats the latched one
    enter_miss();
    redir_cyc(32'h300);
    icache_ready = 1'b1; redirect = 1'b1; redirect_target = 32'h500;
    cyc(1, "exit_redir_wins", 1'b1, 32'h500, 1'b1, 1'b1, 1'b0);
    redirect = 1'b0;

    // Redirect in FETCH overrides miss and stall; stays in FETCH
    hazard_stall = 1'b1; icache_miss = 1'b1; redirect = 1'b1; redirect_target = 32'h80;
    cyc(1, "redir_stall", 1'b1, 32'h80, 1'b1, 1'b1, 1'b0);
    hazard_stall = 1'b0; icache_miss = 1'b0; redirect = 1'b0; pc = 32'h80;
    cyc(1, "stay_fetch", 1'b1, 32'h84, 1'b1, 1'b0, 1'b0);
    hazard_stall = 1'b1;
    cyc(1, "hazard_hold", 1'b0, '0, 1'b1, 1'b0, 1'b0);
    hazard_stall = 1'b0; icache_ready = 1'b0;
    cyc(1, "not_ready", 1'b0, '0, 1'b1, 1'b0, 1'b0);
    icache_ready = 1'b1; pc = 32'hFFFF_FFFC;
    cyc(1, "wrap", 1'b1, 32'h0, 1'b1, 1'b0, 1'b0);

    // Misaligned redirect, direct and via the latched path
    pc = 32'h40; redirect = 1'b1; redirect_target = 32'h202;
    cyc(1, "misalign", 1'b1, mis_nxt, 1'b1, 1'b1, mis_tr);
    redirect = 1'b0;
    enter_miss();
    redir_cyc(32'h203);
    icache_ready = 1'b1;
    cyc(1, "misalign_pend", 1'b1, mis_nxt, 1'b1, 1'b1, mis_tr);

    // Reset mid-refill with a pending redirect leaves nothing behind
    enter_miss();
    redir_cyc(32'h600);
    #2 reset = 1'b1;
    cyc(1, "rst_mid", 1'b0, '0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0; track = 1'b1; pc = '0; icache_ready = 1'b1;
    cyc(1, "boot_mid", 1'b1, 32'h0, 1'b0, 1'b0, 1'b0);
    cyc(1, "no_residual", 1'b1, 32'h4, 1'b1, 1'b0, 1'b0);

    // Halt during refill is terminal until reset
    track = 1'b0; pc = 32'h40;
    enter_miss();
    redir_cyc(32'h600);
    halt = 1'b1;
    cyc(1, "halt_mw", 1'b0, '0, 1'b0, 1'b0, 1'b0);
    halt = 1'b0; icache_ready = 1'b1; redirect = 1'b1; redirect_target = 32'h700;
    repeat (3) cyc(1, "halted", 1'b0, '0, 1'b0, 1'b0, 1'b0);
    redirect = 1'b0; reset = 1'b1;
    cyc(1, "rst2", 1'b0, '0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0; track = 1'b1; pc = '0; halt = 1'b1;
    cyc(1, "boot_halt_ign", 1'b1, 32'h0, 1'b0, 1'b0, 1'b0);
    halt = 1'b0;
    cyc(1, "seq4_again", 1'b1, 32'h4, 1'b1, 1'b0, 1'b0);

    cyc(0, "", 1'b0, '0, 1'b0, 1'b0, 1'b0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
